// File: rtl/ctrl_seq_pkg.sv
// Shared opcode constants, FSM state encoding and opcode classification for ctrl_seq.
// Opcode sits in the top nibble of every instruction word.
package ctrl_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FETCH = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_JNZ  = 4'hA;
    localparam logic [3:0] OP_CALL = 4'hB;
    localparam logic [3:0] OP_RET  = 4'hC;
    localparam logic [3:0] OP_HLT  = 4'hF;

    // Control-flow opcodes are consumed by the sequencer and never reach the datapath.
    function automatic logic is_ctrl_op(input logic [3:0] op);
        return ((op >= OP_JMP) && (op <= OP_RET)) || (op == OP_HLT);
    endfunction

endpackage

// File: rtl/ctrl_seq_ret_stack.sv
// Return-address LIFO, SD entries of AW bits; top entry readable combinationally.
// Push when full and pop when empty are ignored; the caller flags the error.
module ret_stack #(
    parameter int AW = 4,
    parameter int SD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [AW-1:0] push_dat_i,
    output logic [AW-1:0] top_dat_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int PW = $clog2(SD);

    logic [PW:0]   sp_q, sp_d;
    logic [PW-1:0] top_idx;
    logic [AW-1:0] stk_mem [SD];

    assign full_o    = (sp_q == (PW+1)'(SD));
    assign empty_o   = (sp_q == '0);
    // With SD a power of two the low pointer bits wrap to the last slot when full.
    assign top_idx   = sp_q[PW-1:0] - PW'(1);
    assign top_dat_o = stk_mem[top_idx];

    always_comb begin
        sp_d = sp_q;
        if (clr_i) begin
            sp_d = '0;
        end else if (push_i && !full_o) begin
            sp_d = sp_q + (PW+1)'(1);
        end else if (pop_i && !empty_o) begin
            sp_d = sp_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o && !clr_i) begin
            stk_mem[sp_q[PW-1:0]] <= push_dat_i;
        end
    end

endmodule

// File: rtl/ctrl_seq.sv
// Two-cycle fetch/execute program sequencer with loadable program memory.
// Optional return stack for CALL/RET enabled by macro CTRL_SEQ_STACK_EN.
module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter  int DW = 4,
    parameter  int AW = 4,
    parameter  int SD = 4,
    localparam int IW = 4 + DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [IW-1:0] instr_i,
    input  logic          start,
    input  logic          zero,
    output logic [IW-1:0] instr,
    output logic [AW-1:0] pc,
    output logic          halted,
    output logic          stk_err,
    inout  wire  [DW-1:0] bus
);

    localparam int DEPTH = 1 << AW;

    generate
        if (AW > DW) begin : g_bad_aw
            $error("ctrl_seq: AW must not exceed DW");
        end
        if ((SD < 2) || ((SD & (SD - 1)) != 0)) begin : g_bad_sd
            $error("ctrl_seq: SD must be a power of two and at least 2");
        end
    endgenerate

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] laddr_q, laddr_d;
    logic [IW-1:0] ir_q, ir_d;
    logic          mem_we;
    logic [IW-1:0] prog_mem [DEPTH];

    logic [3:0]    opcode;
    logic [DW-1:0] operand;
    logic [AW-1:0] target;
    logic [AW-1:0] pc_inc;
    logic          bus_en;

    assign opcode  = ir_q[IW-1 -: 4];
    assign operand = ir_q[DW-1:0];
    assign target  = ir_q[AW-1:0];
    assign pc_inc  = pc_q + AW'(1);

`ifdef CTRL_SEQ_STACK_EN
    logic          err_q, err_d;
    logic          stk_clr, stk_push, stk_pop;
    logic          stk_full, stk_empty;
    logic [AW-1:0] stk_top;

    ret_stack #(
        .AW (AW),
        .SD (SD)
    ) u_ret_stack (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (stk_clr),
        .push_i     (stk_push),
        .pop_i      (stk_pop),
        .push_dat_i (pc_inc),
        .top_dat_o  (stk_top),
        .full_o     (stk_full),
        .empty_o    (stk_empty)
    );
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        laddr_d = laddr_q;
        ir_d    = ir_q;
        mem_we  = 1'b0;
`ifdef CTRL_SEQ_STACK_EN
        err_d    = err_q;
        stk_clr  = 1'b0;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (load) begin
                    state_d = ST_LOAD;
                    laddr_d = '0;
`ifdef CTRL_SEQ_STACK_EN
                    err_d   = 1'b0;
                    stk_clr = 1'b1;
`endif
                end else if ((state_q == ST_IDLE) && start) begin
                    // Each run starts with an empty return stack.
                    state_d = ST_FETCH;
                    pc_d    = '0;
`ifdef CTRL_SEQ_STACK_EN
                    stk_clr = 1'b1;
`endif
                end
            end
            ST_LOAD: begin
                if (load) begin
                    mem_we  = 1'b1;
                    laddr_d = laddr_q + AW'(1);
                end else begin
                    state_d = ST_IDLE;
                    pc_d    = '0;
                end
            end
            ST_FETCH: begin
                ir_d    = prog_mem[pc_q];
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_inc;
                case (opcode)
                    OP_JMP: pc_d = target;
                    OP_JZ:  if (zero)  pc_d = target;
                    OP_JNZ: if (!zero) pc_d = target;
                    OP_HLT: begin
                        state_d = ST_HALT;
                        pc_d    = pc_q;
                    end
`ifdef CTRL_SEQ_STACK_EN
                    OP_CALL: begin
                        if (stk_full) begin
                            state_d = ST_HALT;
                            pc_d    = pc_q;
                            err_d   = 1'b1;
                        end else begin
                            stk_push = 1'b1;
                            pc_d     = target;
                        end
                    end
                    OP_RET: begin
                        if (stk_empty) begin
                            state_d = ST_HALT;
                            pc_d    = pc_q;
                            err_d   = 1'b1;
                        end else begin
                            stk_pop = 1'b1;
                            pc_d    = stk_top;
                        end
                    end
`endif
                    default: pc_d = pc_inc;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            laddr_q <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            laddr_q <= laddr_d;
            ir_q    <= ir_d;
        end
    end

`ifdef CTRL_SEQ_STACK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign stk_err = err_q;
`else
    assign stk_err = 1'b0;
`endif

    // Program memory keeps its contents across reset; writes only happen in LOAD.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            prog_mem[laddr_q] <= instr_i;
        end
    end

    assign bus_en = (state_q == ST_EXEC) && (opcode == OP_LDI);
    assign bus    = bus_en ? operand : {DW{1'bz}};

    assign instr  = ((state_q == ST_EXEC) && !is_ctrl_op(opcode)) ? ir_q : '0;
    assign pc     = pc_q;
    assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed self-checking bench for ctrl_seq; expectations adapt to CTRL_SEQ_STACK_EN.
// The bus carries pull-ups so an undriven bus reads as all ones.
module tb_ctrl_seq;

    localparam int DW = 4;
    localparam int AW = 4;
    localparam int SD = 4;
    localparam int IW = 4 + DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [IW-1:0] instr_i;
    logic          start;
    logic          zero;
    wire  [IW-1:0] instr;
    wire  [AW-1:0] pc;
    wire           halted;
    wire           stk_err;
    wire  [DW-1:0] bus;

    int errors = 0;
    int checks = 0;

    logic [IW-1:0] prog [16];

    for (genvar g = 0; g < DW; g++) begin : g_pu
        pullup (bus[g]);
    end

    ctrl_seq #(.DW(DW), .AW(AW), .SD(SD)) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .instr_i (instr_i),
        .start   (start),
        .zero    (zero),
        .instr   (instr),
        .pc      (pc),
        .halted  (halted),
        .stk_err (stk_err),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [IW-1:0] v);
        for (int i = 0; i < 16; i++) prog[i] = v;
    endtask

    task automatic load_prog();
        load = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            instr_i = prog[i];
            tick();
        end
        load    = 1'b0;
        instr_i = '0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    task automatic run_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; start = 1'b0; zero = 1'b0; instr_i = '0;
        #3;
        chk("rst_pc", pc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_stk_err", stk_err, 0);
        chk("rst_instr", instr, 0);
        chk("rst_bus_z", bus, 4'hF);
        rst = 1'b1;
        tick();

        // LDI then JMP 3, NOPs up to wrap
        fill(8'h00); prog[0] = 8'h15; prog[1] = 8'h83;
        load_prog();
        run_start();
        chk("fetch0_pc", pc, 0);
        chk("fetch0_bus_z", bus, 4'hF);
        chk("fetch0_instr", instr, 0);
        tick();
        chk("ldi_instr", instr, 8'h15);
        chk("ldi_bus", bus, 4'h5);
        tick();
        chk("fetch1_bus_z", bus, 4'hF);
        tick();
        chk("jmp_instr_nop", instr, 0);
        tick();
        chk("jmp_pc", pc, 3);
        load = 1'b1; start = 1'b1;
        repeat (26) tick();
        load = 1'b0; start = 1'b0;
        chk("wrap_pc", pc, 0);
        chk("wrap_not_halted", halted, 0);
        tick();
        chk("wrap_instr", instr, 8'h15);
        do_reset();

        // JZ / JNZ
        fill(8'h00); prog[0] = 8'h9A; prog[1] = 8'hA7;
        load_prog();
        zero = 1'b1;
        run_start(); tick(); tick();
        chk("jz_taken_pc", pc, 4'hA);
        do_reset();
        zero = 1'b0;
        run_start(); tick(); tick();
        chk("jz_not_taken_pc", pc, 1);
        tick(); tick();
        chk("jnz_taken_pc", pc, 7);
        do_reset();

        // CALL at 2 to 6, RET back to 3, HLT at 3
        fill(8'h00); prog[0] = 8'h20; prog[1] = 8'h21; prog[2] = 8'hB6;
        prog[3] = 8'hF0; prog[6] = 8'hC0;
        load_prog();
        run_start();
        repeat (5) tick();
        chk("call_instr_nop", instr, 0);
        tick();
`ifdef CTRL_SEQ_STACK_EN
        chk("call_pc", pc, 6);
        tick(); tick();
        chk("ret_pc", pc, 3);
`else
        chk("call_nop_pc", pc, 3);
`endif
        tick(); tick();
        chk("call_hlt_halted", halted, 1);
        chk("call_hlt_pc", pc, 3);
        do_reset();

        // SD+1 nested calls
        fill(8'h00); prog[0] = 8'hB1; prog[1] = 8'hB2; prog[2] = 8'hB3;
        prog[3] = 8'hB4; prog[4] = 8'hB5; prog[5] = 8'hF0;
        load_prog();
        run_start();
        repeat (14) tick();
        chk("nest_halted", halted, 1);
`ifdef CTRL_SEQ_STACK_EN
        chk("nest_stk_err", stk_err, 1);
        chk("nest_pc", pc, 4);
`else
        chk("nest_stk_err", stk_err, 0);
        chk("nest_pc", pc, 5);
`endif
        do_reset();
        chk("nest_rst_err", stk_err, 0);

        // RET on empty stack, then load pulse
        fill(8'h00); prog[0] = 8'hC0; prog[1] = 8'hF0;
        load_prog();
        run_start();
        repeat (6) tick();
        chk("ret_empty_halted", halted, 1);
`ifdef CTRL_SEQ_STACK_EN
        chk("ret_empty_err", stk_err, 1);
        chk("ret_empty_pc", pc, 0);
`else
        chk("ret_empty_err", stk_err, 0);
        chk("ret_empty_pc", pc, 1);
`endif
        load = 1'b1;
        tick();
        chk("load_entry_halted", halted, 0);
        chk("load_entry_err", stk_err, 0);
        load = 1'b0;
        tick();
        chk("load_exit_pc", pc, 0);

        // HLT freezes pc and ignores start
        fill(8'h00); prog[0] = 8'h20; prog[1] = 8'h21; prog[2] = 8'hF0;
        load_prog();
        run_start();
        repeat (6) tick();
        chk("hlt_halted", halted, 1);
        chk("hlt_pc", pc, 2);
        start = 1'b1;
        repeat (10) tick();
        start = 1'b0;
        chk("hlt_start_ignored", halted, 1);
        chk("hlt_pc_frozen", pc, 2);
        chk("hlt_instr_nop", instr, 0);
        do_reset();

        // Reset in the middle of a load
        for (int i = 0; i < 16; i++) prog[i] = 8'h20 + 8'(i);
        load_prog();
        load = 1'b1;
        tick();
        instr_i = 8'h31; tick();
        instr_i = 8'h32; tick();
        instr_i = 8'h33;
        rst = 1'b0;
        #1;
        chk("midload_pc", pc, 0);
        chk("midload_halted", halted, 0);
        tick();
        rst = 1'b1; load = 1'b0; instr_i = '0;
        run_start();
        tick();
        chk("midload_word0", instr, 8'h31);
        tick(); tick();
        chk("midload_word1", instr, 8'h32);
        tick(); tick();
        chk("midload_word2_kept", instr, 8'h22);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq
Interface
REQ-001 SHALL have parameter DW, 4, data/operand width; IW = 4+DW derived; AW <= DW enforced by elaboration check.
REQ-002 SHALL have parameter AW, 4, program address width; memory depth 2**AW words of IW bits.
REQ-003 SHALL have parameter SD, 4, return-stack depth (entries, power of two, >=2).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 load  input  1  program-load enable.
REQ-007 instr_i  input  IW  instruction word to store during load.
REQ-008 start  input  1  begin execution from address 0.
REQ-009 zero  input  1  datapath zero flag for conditional jumps.
REQ-010 instr  output  IW  instruction presented to datapath.
REQ-011 pc  output  AW  current program counter.
REQ-012 halted  output  1  high in HALT state.
REQ-013 stk_err  output  1  sticky stack overflow/underflow flag.
REQ-014 bus  inout  DW  data bus; driven only as in REQ-024, else high-Z.
Function
REQ-015 FSM states IDLE, LOAD, FETCH, EXEC, HALT; opcode = instr[IW-1:IW-4], operand = low DW bits, target = low AW bits.
REQ-016 IDLE/HALT: load=1 -> LOAD with load address 0; else IDLE: start=1 -> FETCH with pc=0; HALT holds until load or reset.
REQ-017 LOAD: each cycle load=1 writes instr_i to mem[load address], address increments, wraps 2**AW-1 -> 0; load=0 -> IDLE, pc=0.
REQ-018 load and start ignored in FETCH/EXEC; load has priority over start in IDLE.
REQ-019 FETCH: IR <= mem[pc] (one cycle) -> EXEC; each instruction takes exactly 2 cycles.
REQ-020 EXEC: pc <= pc+1 modulo 2**AW unless a control-flow op below; -> FETCH.
REQ-021 Opcodes: 0x8 JMP pc<=target; 0x9 JZ pc<=target if zero=1; 0xA JNZ pc<=target if zero=0; zero sampled in EXEC.
REQ-022 0xB CALL push pc+1, pc<=target; 0xC RET pc<=pop; 0xF HLT -> HALT, pc unchanged.
REQ-023 CALL with SD entries full or RET with stack empty: no push/pop, stk_err<=1, -> HALT.
REQ-024 0x1 LDI: bus driven with operand during EXEC only.
REQ-025 instr = IR during EXEC for non-control-flow opcodes; all-zero (NOP) in every other state and for opcodes 0x8-0xC, 0xF.
REQ-026 halted = 1 exactly while in HALT; stk_err cleared only by reset or entry to LOAD.
Reset
REQ-027 rst=0 asynchronously: state IDLE, pc=0, load address 0, IR=0, stack pointer 0, stk_err=0, halted=0, instr=0, bus high-Z.
REQ-028 Program memory not cleared by reset; reset mid-LOAD/EXEC aborts with no further write.
Configuration
REQ-029 Macro CTRL_SEQ_STACK_EN defined: CALL/RET and stk_err per REQ-022/023.
REQ-030 Macro undefined: no stack logic; CALL/RET execute as NOP (pc+1), stk_err tied 0.
Structure
REQ-031 Package ctrl_seq_pkg holds opcode constants and FSM state enum.
REQ-032 Return stack is sub-module ret_stack (push, pop, full, empty, SD x AW storage).
Verification
REQ-033 Load {0x15, 0x83}, start -> instr=0x15 and bus=0x5 in first EXEC, pc reaches 3 then wraps correctly, bus high-Z in FETCH.
REQ-034 JZ 0x9A with zero=1 -> pc=0xA; same with zero=0 -> pc=old+1.
REQ-035 CALL 0xB6 at 2, RET at 6 -> pc 6 then 3; SD+1 nested CALLs -> stk_err=1, halted=1 (macro on); macro off -> pc increments.
REQ-036 RET with empty stack -> stk_err=1, HALT; then load pulse -> LOAD, stk_err=0.
REQ-037 rst low mid-LOAD after 2 writes -> IDLE, pc=0, written words retained, third word unwritten.
REQ-038 HLT 0xF0 -> halted=1, pc frozen, start ignored for 10 cycles.
